// File: rtl/vending_machine_param_if.sv
`default_nettype none
// ============================================================================
//  Module   : vending_machine_param_if
//  Brief    : Coin/cancel inputs and dispense/change/debug outputs of the
//             parametrised vending machine, bundled with master/slave views.
//  Revision : 1.0 - initial release
// ============================================================================
interface vending_machine_param_if #(
   parameter int CREDIT_W = 4,
   parameter int CNT_W    = 8
);
   logic                one;
   logic                two;
   logic                five;
   logic                cancel;
   logic                d;
   logic [CREDIT_W-1:0] r;
   logic                rej;
   logic [1:0]          cs;
   logic [1:0]          ns;
   logic [CREDIT_W-1:0] credit;
   logic [CNT_W-1:0]    vend_cnt;

   // Coin acceptor / controller side
   modport master (
      output one, two, five, cancel,
      input  d, r, rej, cs, ns, credit, vend_cnt
   );

   // Vending machine side
   modport slave (
      input  one, two, five, cancel,
      output d, r, rej, cs, ns, credit, vend_cnt
   );
endinterface
`default_nettype wire

// File: rtl/vending_machine_param.sv
`default_nettype none
// ============================================================================
//  Module   : vending_machine_param
//  Brief    : Single-price coin vending FSM with parametrised coin values,
//             cancel/refund, coin rejection and a wrapping vend counter.
//  Revision : 1.0 - initial release
// ============================================================================
module vending_machine_param #(
   parameter int PRICE    = 4,
   parameter int VAL_ONE  = 1,
   parameter int VAL_TWO  = 2,
   parameter int VAL_FIVE = 5,
   parameter int CREDIT_W = 4,
   parameter int CNT_W    = 8
) (
   input  wire logic               clk,
   input  wire logic               reset,
   vending_machine_param_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCUM  = 2'd1,
      S_VEND   = 2'd2,
      S_REFUND = 2'd3
   } state_t;

   // Sums carry one guard bit so credit + coin never wraps.
   localparam logic [CREDIT_W:0] c_price    = (CREDIT_W+1)'(PRICE);
   localparam logic [CREDIT_W:0] c_val_one  = (CREDIT_W+1)'(VAL_ONE);
   localparam logic [CREDIT_W:0] c_val_two  = (CREDIT_W+1)'(VAL_TWO);
   localparam logic [CREDIT_W:0] c_val_five = (CREDIT_W+1)'(VAL_FIVE);

   state_t              r_state;
   logic [CREDIT_W-1:0] r_credit;
   logic [CREDIT_W-1:0] r_change;
   logic                r_rej;
   logic [CNT_W-1:0]    r_vend_cnt;

   state_t              w_ns;
   logic [CREDIT_W-1:0] w_credit_nxt;
   logic [CREDIT_W-1:0] w_change_nxt;
   logic                w_rej_nxt;
   logic                w_vend;
   logic [1:0]          w_ncoin;
   logic                w_valid;
   logic                w_multi;
   logic                w_any;
   logic [CREDIT_W:0]   w_val;
   logic [CREDIT_W:0]   w_sum;
   logic [CREDIT_W:0]   w_over;

   // Coin decode: a single coin carries its value, simultaneous coins carry none.
   always_comb begin
      w_ncoin = 2'(bus.one) + 2'(bus.two) + 2'(bus.five);
      w_valid = (w_ncoin == 2'd1);
      w_multi = (w_ncoin >= 2'd2);
      w_any   = (w_ncoin != 2'd0);
      w_val   = '0;
      if (w_valid) begin
         if (bus.one)      w_val = c_val_one;
         else if (bus.two) w_val = c_val_two;
         else              w_val = c_val_five;
      end
      w_sum  = {1'b0, r_credit} + w_val;
      w_over = w_sum - c_price;
   end

   // Next-state and next-datapath decision; cancel outranks vending.
   always_comb begin
      w_ns         = r_state;
      w_credit_nxt = r_credit;
      w_change_nxt = '0;
      w_rej_nxt    = 1'b0;
      w_vend       = 1'b0;
      if (reset) begin
         w_ns = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE, S_ACCUM: begin
               if (bus.cancel) begin
                  w_credit_nxt = '0;
                  if (w_sum != '0) begin
                     w_ns         = S_REFUND;
                     w_change_nxt = w_sum[CREDIT_W-1:0];
                  end else begin
                     w_ns = S_IDLE;
                  end
               end else if (w_valid) begin
                  if (w_sum >= c_price) begin
                     w_ns         = S_VEND;
                     w_change_nxt = w_over[CREDIT_W-1:0];
                     w_credit_nxt = '0;
                     w_vend       = 1'b1;
                  end else begin
                     w_ns         = S_ACCUM;
                     w_credit_nxt = w_sum[CREDIT_W-1:0];
                  end
               end else if (w_multi) begin
                  w_rej_nxt = 1'b1;
               end
            end
            default: begin
               // Busy dispensing or refunding: coins bounce, cancel is ignored.
               w_ns      = S_IDLE;
               w_rej_nxt = w_any;
            end
         endcase
      end
   end

   // State and datapath registers; reset discards credit without refund.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_credit   <= '0;
         r_change   <= '0;
         r_rej      <= 1'b0;
         r_vend_cnt <= '0;
      end else begin
         r_state    <= w_ns;
         r_credit   <= w_credit_nxt;
         r_change   <= w_change_nxt;
         r_rej      <= w_rej_nxt;
         if (w_vend) r_vend_cnt <= r_vend_cnt + CNT_W'(1);
      end
   end

   assign bus.d        = (r_state == S_VEND);
   assign bus.r        = r_change;
   assign bus.rej      = r_rej;
   assign bus.cs       = r_state;
   assign bus.ns       = w_ns;
   assign bus.credit   = r_credit;
   assign bus.vend_cnt = r_vend_cnt;

endmodule
`default_nettype wire
